// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the sequence-detector stimulus controller.
package seq_ctrl_pkg;

   localparam int PAT_W = 16;
   localparam int CNT_W = 5;
   localparam logic [CNT_W-1:0] NO_HIT = 5'h1F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Lengths above the pattern width issue the whole pattern.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
      return (len > CNT_W'(PAT_W)) ? CNT_W'(PAT_W) : len;
   endfunction

endpackage

// File: rtl/seq_det_piso.sv
// Loadable right-shift register feeding the serial bit stream, LSB first.
module seq_det_piso
   import seq_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [PAT_W-1:0] data_i,
   output logic             nxt_lsb_o
);

   logic [PAT_W-1:0] shreg_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shreg_q <= '0;
      end else if (load_i) begin
         shreg_q <= data_i;
      end else if (shift_i) begin
         shreg_q <= {1'b0, shreg_q[PAT_W-1:1]};
      end
   end

   // Bit 0 as it will be after this edge, so the top can register bit_o directly.
   always_comb begin
      nxt_lsb_o = shreg_q[0];
      if (load_i) begin
         nxt_lsb_o = data_i[0];
      end else if (shift_i) begin
         nxt_lsb_o = shreg_q[1];
      end
   end

endmodule

// File: rtl/seq_det_ctrl.sv
// Drives a serial pattern into a sequence detector and counts its match flags.
// Optional feature macro: SEQ_DET_CTRL_FIRST_HIT_EN adds first_hit_o.
module seq_det_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int DRAIN_CYC = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [PAT_W-1:0] pattern_i,
   input  logic [CNT_W-1:0] len_i,
   input  logic             flag_i,
   output logic             bit_o,
   output logic             bit_vld_o,
   output logic             busy_o,
   output logic             done_o,
`ifdef SEQ_DET_CTRL_FIRST_HIT_EN
   output logic [CNT_W-1:0] first_hit_o,
`endif
   output logic [CNT_W-1:0] hit_cnt_o
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [2:0]       drn_q, drn_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic             bit_q, bit_d;
   logic             vld_q, vld_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load, shift, nxt_lsb, accept, counting;

   seq_det_piso u_piso (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (load),
      .shift_i   (shift),
      .data_i    (pattern_i),
      .nxt_lsb_o (nxt_lsb)
   );

   assign accept   = (state_q == ST_IDLE) && start_i;
   assign counting = (state_q == ST_SHIFT) || (state_q == ST_DRAIN);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      drn_d   = drn_q;
      hit_d   = hit_q;
      load    = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               load    = 1'b1;
               len_d   = clamp_len(len_i);
               cnt_d   = '0;
               drn_d   = '0;
               hit_d   = '0;
               state_d = (clamp_len(len_i) == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            shift = 1'b1;
            cnt_d = cnt_q + 5'd1;
            drn_d = '0;
            if (cnt_d == len_q) begin
               state_d = (DRAIN_CYC == 0) ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            drn_d = drn_q + 3'd1;
            if (drn_d == 3'(DRAIN_CYC)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      if (flag_i && counting && (hit_q != '1)) begin
         hit_d = hit_q + 5'd1;
      end

      vld_d  = (state_d == ST_SHIFT);
      bit_d  = vld_d & nxt_lsb;
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         drn_q   <= '0;
         hit_q   <= '0;
         bit_q   <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         drn_q   <= drn_d;
         hit_q   <= hit_d;
         bit_q   <= bit_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bit_o     = bit_q;
   assign bit_vld_o = vld_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign hit_cnt_o = hit_q;

`ifdef SEQ_DET_CTRL_FIRST_HIT_EN
   logic [CNT_W-1:0] first_q, first_d;

   // In SHIFT the bit on the wire counts as issued; in DRAIN all len bits are out.
   always_comb begin
      first_d = first_q;
      if (accept) begin
         first_d = NO_HIT;
      end else if (flag_i && (first_q == NO_HIT)) begin
         if (state_q == ST_SHIFT) begin
            first_d = cnt_q + 5'd1;
         end else if (state_q == ST_DRAIN) begin
            first_d = cnt_q;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         first_q <= NO_HIT;
      end else begin
         first_q <= first_d;
      end
   end

   assign first_hit_o = first_q;
`endif

endmodule
